// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order word fetches, buffers up to two
// responses for decode, and handles execute redirects by flushing and draining.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        misaligned_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CW    = 2;
  localparam int unsigned SW    = CW + 1;
  localparam int unsigned DEPTH = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] rsp_pc, rsp_pc_nxt;
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic            rd_ptr, rd_ptr_nxt;
  logic            wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [CW-1:0]   outstanding, outstanding_nxt;
  logic [CW-1:0]   drop, drop_nxt;
  logic            misaligned_nxt;
  logic            req_fire, rsp_fire, push, pop;
  logic [XLEN-1:0] jump_pc;

  assign jump_pc         = {jump_target[XLEN-1:2], 2'b00};
  assign instr_valid_out = (count != '0);
  assign instr_out       = instr_valid_out ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign pc_out          = instr_valid_out ? fifo_pc[rd_ptr] : rsp_pc;
  assign imem_addr       = fetch_pc;

  // Outstanding requests plus buffered entries never exceed the FIFO depth,
  // so every response always has a slot waiting for it.
  assign imem_req_valid  = (state == RUN) && !jump_valid &&
                           ((SW'(outstanding) + SW'(count)) < SW'(DEPTH));

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (outstanding != '0);
  assign push     = rsp_fire && (drop == '0) && !jump_valid;
  assign pop      = instr_valid_out && !stall_in && !jump_valid;

  // Next-state logic: redirect overrides every other update
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    rd_ptr_nxt      = rd_ptr;
    wr_ptr_nxt      = wr_ptr;
    count_nxt       = count;
    drop_nxt        = drop;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);
    misaligned_nxt  = jump_valid && (jump_target[1:0] != 2'b00);

    if (jump_valid) begin
      fetch_pc_nxt = jump_pc;
      rsp_pc_nxt   = jump_pc;
      rd_ptr_nxt   = 1'b0;
      wr_ptr_nxt   = 1'b0;
      count_nxt    = '0;
      drop_nxt     = outstanding_nxt;
      state_nxt    = (outstanding_nxt != '0) ? DRAIN : RUN;
    end else begin
      if (req_fire) fetch_pc_nxt = fetch_pc + XLEN'(4);
      if (push) begin
        rsp_pc_nxt = rsp_pc + XLEN'(4);
        wr_ptr_nxt = ~wr_ptr;
      end
      if (pop) rd_ptr_nxt = ~rd_ptr;
      count_nxt = count + CW'(push) - CW'(pop);
      if (rsp_fire && (drop != '0)) drop_nxt = drop - CW'(1);

      case (state)
        BOOT:    state_nxt = RUN;
        RUN:     state_nxt = RUN;
        DRAIN:   if (drop_nxt == '0) state_nxt = RUN;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= BOOT;
      fetch_pc       <= RESET_PC;
      rsp_pc         <= RESET_PC;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      count          <= '0;
      outstanding    <= '0;
      drop           <= '0;
      misaligned_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      fetch_pc       <= fetch_pc_nxt;
      rsp_pc         <= rsp_pc_nxt;
      rd_ptr         <= rd_ptr_nxt;
      wr_ptr         <= wr_ptr_nxt;
      count          <= count_nxt;
      outstanding    <= outstanding_nxt;
      drop           <= drop_nxt;
      misaligned_out <= misaligned_nxt;
    end
  end

  // Entry payload needs no reset; occupancy qualifies it
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= rsp_pc;
      fifo_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a latency-programmable memory model answers
// fetches, directed phases push expected {pc, instr}, a monitor checks pops.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        stall_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        misaligned_out;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t pend[$];
  exp_t  expq[$];
  int    cyc      = 0;
  int    lat      = 1;
  int    consumed = 0;
  int    checks   = 0;
  int    errors   = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .jump_valid(jump_valid),
    .jump_target(jump_target), .stall_in(stall_in),
    .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid_out(instr_valid_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0013_0000;
  endfunction

  // Memory model: in-order responses 'lat' cycles after acceptance
  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem(pend[0].addr);
        void'(pend.pop_front());
      end
      if (imem_req_valid && imem_req_ready)
        pend.push_back('{addr: imem_addr, due: cyc + 1 + lat});
    end
  end

  // Monitor: every instruction decode accepts must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && instr_valid_out && !stall_in && !jump_valid) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h, scoreboard empty", pc_out, instr_out);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (pc_out !== e.pc || instr_out !== e.instr) begin
          errors++;
          $display("FAIL sb_instr: got pc %h instr %h expected pc %h instr %h",
                   pc_out, instr_out, e.pc, e.instr);
        end
      end
      consumed++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      expq.push_back('{pc: a, instr: mem(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (consumed < target && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (consumed < target) begin
      errors++;
      $display("FAIL run_until: consumed %0d required %0d", consumed, target);
    end
  endtask

  task automatic wait_req(input logic level);
    int n;
    n = 0;
    while (imem_req_valid !== level && n < 50) begin
      tick();
      n++;
    end
    chk("wait_req_valid", 32'(imem_req_valid), 32'(level));
  endtask

  task automatic jump(input logic [31:0] t);
    jump_valid  = 1'b1;
    jump_target = t;
    tick();
    jump_valid  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid_out), 32'd0);
    chk({tag, "_instr_out"}, instr_out, NOP);
    chk({tag, "_pc_out"}, pc_out, 32'h0000_0000);
    chk({tag, "_misaligned"}, 32'(misaligned_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; jump_valid = 1'b0; jump_target = '0; stall_in = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");

    // Boot lasts one cycle without a request, then sequential fetch from 0
    rst_n = 1'b1;
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_addr, 32'h0000_0000);
    expect_seq(32'h0, 6);
    run_until(6);
    stall_in = 1'b1;

    // Stall with a full FIFO: head frozen, no requests
    expect_seq(32'h18, 2);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_instr_valid", 32'(instr_valid_out), 32'd1);
      chk("stall_pc_hold", pc_out, 32'h0000_0018);
      chk("stall_instr_hold", instr_out, mem(32'h18));
      tick();
    end
    stall_in = 1'b0;
    run_until(8);
    stall_in = 1'b1;

    // Memory not ready: address held, pc not advanced
    imem_req_ready = 1'b0;
    jump(32'h0000_0200);
    wait_req(1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("notready_valid", 32'(imem_req_valid), 32'd1);
      chk("notready_addr", imem_addr, 32'h0000_0200);
      tick();
    end
    expect_seq(32'h200, 3);
    imem_req_ready = 1'b1;
    stall_in = 1'b0;
    run_until(11);
    stall_in = 1'b1;

    // Address wrap through 0xFFFF_FFFC
    jump(32'hFFFF_FFF8);
    chk("aligned_no_misaligned", 32'(misaligned_out), 32'd0);
    expect_seq(32'hFFFF_FFF8, 4);
    stall_in = 1'b0;
    run_until(15);
    stall_in = 1'b1;

    // Misaligned redirect: one-cycle pulse, fetch from cleared low bits
    jump(32'h0000_0102);
    chk("misaligned_pulse", 32'(misaligned_out), 32'd1);
    chk("misaligned_flush", 32'(instr_valid_out), 32'd0);
    tick();
    chk("misaligned_clear", 32'(misaligned_out), 32'd0);
    expect_seq(32'h100, 2);
    stall_in = 1'b0;
    run_until(17);
    stall_in = 1'b1;

    // Redirect with two outstanding slow fetches, then redirect again in drain
    imem_req_ready = 1'b0;
    jump(32'h0000_0300);
    wait_req(1'b1);
    lat = 4;
    imem_req_ready = 1'b1;
    tick();
    wait_req(1'b0);
    chk("two_outstanding_fifo_empty", 32'(instr_valid_out), 32'd0);
    jump(32'h0000_0180);
    jump(32'h0000_0100);
    chk("drain_no_req", 32'(imem_req_valid), 32'd0);
    lat = 1;
    expect_seq(32'h100, 3);
    stall_in = 1'b0;
    run_until(20);
    stall_in = 1'b1;

    // Reset with fetches in flight abandons them
    lat = 3;
    jump(32'h0000_0400);
    repeat (2) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("midreset");
    lat = 1;
    rst_n = 1'b1;
    expect_seq(32'h0, 3);
    stall_in = 1'b0;
    run_until(23);
    stall_in = 1'b1;
    repeat (3) tick();
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction driven when no valid instruction is held.
REQ-003 SHALL use one clock; reset is synchronous and active-low (ports clk, rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_addr  output  32  fetch address, word aligned.
REQ-009 imem_rsp_valid  input  1  response data valid; responses return in request order.
REQ-010 imem_rsp_data  input  32  fetched instruction word.
REQ-011 jump_valid  input  1  redirect request from execute (jump taken).
REQ-012 jump_target  input  32  redirect address.
REQ-013 stall_in  input  1  decode stage cannot accept an instruction this cycle.
REQ-014 instr_out  output  32  instruction presented to decode (instr_in of decode).
REQ-015 pc_out  output  32  address of instr_out.
REQ-016 instr_valid_out  output  1  instr_out/pc_out hold a real fetched instruction.
REQ-017 misaligned_out  output  1  one-cycle pulse: jump_target[1:0] was nonzero.

Function
REQ-018 SHALL contain a 2-entry FIFO of {pc, instr}; outstanding requests plus FIFO occupancy SHALL never exceed 2.
REQ-019 SHALL implement FSM states BOOT, RUN, DRAIN; reset enters BOOT; BOOT -> RUN after exactly one cycle, issuing no request in BOOT.
REQ-020 In RUN, imem_req_valid SHALL be 1 iff outstanding+occupancy < 2 and jump_valid = 0; imem_addr = fetch pc.
REQ-021 Handshake completes when imem_req_valid & imem_req_ready; fetch pc SHALL then advance by 4 (mod 2^32 wrap) and outstanding SHALL increment; imem_addr/valid SHALL stay stable until accepted.
REQ-022 Accepted response (drop count 0) SHALL push {rsp_pc, imem_rsp_data} into FIFO; rsp_pc advances by 4 per accepted response.
REQ-023 instr_valid_out = FIFO not empty; instr_out/pc_out = FIFO head; when empty instr_out = NOP_INSTR, pc_out = rsp_pc.
REQ-024 Head SHALL pop when instr_valid_out & !stall_in; while stall_in = 1 head SHALL hold unchanged; push and pop in one cycle SHALL keep occupancy constant.
REQ-025 jump_valid SHALL have priority over stall_in, requests and pushes: FIFO cleared, fetch pc and rsp_pc <= {jump_target[31:2],2'b00}, drop count <= outstanding (including any response arriving that cycle being discarded).
REQ-026 jump_valid with jump_target[1:0] != 0 SHALL pulse misaligned_out next cycle; redirect still proceeds with low bits cleared.
REQ-027 After redirect, state SHALL be DRAIN if drop count > 0 else RUN; in DRAIN no requests issue, each imem_rsp_valid decrements drop count and is discarded; DRAIN -> RUN when drop count reaches 0.
REQ-028 Redirect while in DRAIN SHALL recompute drop count from current outstanding and remain/leave DRAIN per REQ-027.
REQ-029 imem_rsp_valid with outstanding = 0 SHALL be ignored.

Reset
REQ-030 rst_n = 0 at a clock edge SHALL set state BOOT, fetch pc/rsp_pc = RESET_PC, FIFO empty, outstanding 0, drop count 0, imem_req_valid 0, instr_valid_out 0, instr_out NOP_INSTR, pc_out RESET_PC, misaligned_out 0; reset mid-transaction SHALL abandon all in-flight responses.

Verification
REQ-031 Reset, ready=1, 1-cycle response -> addrs 0x0,0x4,0x8 in order; instr_out matches memory, pc_out = 0x0,0x4,0x8, one per cycle.
REQ-032 Hold stall_in=1 for 5 cycles with FIFO full -> imem_req_valid 0, instr_out/pc_out unchanged; release -> next two instructions in order, no loss or duplication.
REQ-033 jump_valid, jump_target 0x100 with 2 outstanding -> FIFO flushed, both old responses dropped in DRAIN, next pc_out = 0x100.
REQ-034 jump_target 0x102 -> misaligned_out pulses one cycle, fetch resumes at 0x100.
REQ-035 imem_req_ready=0 for 4 cycles -> imem_addr stable, pc not advanced; fetch pc 0xFFFF_FFFC -> next 0x0000_0000.
